// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 16;
  localparam int MEM_BYTES = 16384;

  localparam logic PORT_LS = 1'b0;
  localparam logic PORT_IF = 1'b1;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a port-1 starvation counter.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic       rr_last_q, rr_last_d;
  logic [1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0] gnt;

  // Grant selection: on conflict the port that did not win last goes, unless port 1 is starving.
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt = 2'b00;
    end else if (req_i == 2'b11) begin
      if ((starve_cnt_q == 2'd3) || (rr_last_q == PORT_LS)) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end else begin
      gnt = req_i;
    end
  end

  // Next-state for rr_last and the saturating starvation counter.
  always_comb begin
    rr_last_d    = rr_last_q;
    starve_cnt_d = starve_cnt_q;
    if (gnt[1]) begin
      rr_last_d = PORT_IF;
    end else if (gnt[0]) begin
      rr_last_d = PORT_LS;
    end else begin
      rr_last_d = rr_last_q;
    end
    if (gnt[1] || !req_i[1]) begin
      starve_cnt_d = 2'd0;
    end else if (starve_cnt_q != 2'd3) begin
      starve_cnt_d = starve_cnt_q + 2'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q    <= PORT_IF;
      starve_cnt_q <= 2'd0;
    end else begin
      rr_last_q    <= rr_last_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign gnt_o = gnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between a load/store port and a fetch port,
// rejecting misaligned/out-of-range accesses and routing read data back.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_rb,
  output logic              mem_wb,
  output logic [ADDR_W-1:0] mem_adrb,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 2);

  logic [1:0]        gnt;
  logic              any_gnt, sel_we, legal;
  logic [ADDR_W-1:0] sel_addr;
  state_e            state_q, state_d;
  logic              resp_port_q, resp_port_d;
  logic              resp_err_q, resp_err_d;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req_i({p1_req, p0_req}),
    .gnt_o(gnt)
  );

  assign any_gnt  = gnt[0] | gnt[1];
  assign sel_addr = gnt[1] ? p1_addr : p0_addr;
  assign sel_we   = gnt[0] & p0_we;
  assign legal    = (sel_addr[0] == 1'b0) && (sel_addr <= MAX_ADDR);

  assign p0_gnt   = gnt[0];
  assign p1_gnt   = gnt[1];
  assign mem_rb   = any_gnt & legal & ~sel_we;
  assign mem_wb   = any_gnt & legal & sel_we;
  assign mem_adrb = (mem_rb | mem_wb) ? sel_addr : '0;
  assign mem_din  = mem_wb ? p0_wdata : '0;

  // A response is owed for every granted read and for every rejected access.
  always_comb begin
    state_d     = IDLE;
    resp_port_d = resp_port_q;
    resp_err_d  = resp_err_q;
    if (any_gnt && (!legal || !sel_we)) begin
      state_d     = RESP;
      resp_port_d = gnt[1];
      resp_err_d  = !legal;
    end else begin
      state_d = IDLE;
    end
  end

  // Response tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      resp_port_q <= PORT_LS;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_port_q <= resp_port_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign p0_rvalid = !rst && (state_q == RESP) && (resp_port_q == PORT_LS);
  assign p1_rvalid = !rst && (state_q == RESP) && (resp_port_q == PORT_IF);
  assign p0_err    = p0_rvalid & resp_err_q;
  assign p1_err    = p1_rvalid & resp_err_q;
  assign p0_rdata  = (p0_rvalid && !resp_err_q) ? mem_dout : '0;
  assign p1_rdata  = (p1_rvalid && !resp_err_q) ? mem_dout : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: byte memory model, reference image and response scoreboard.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req;
  logic [14:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_rb, mem_wb;
  logic [14:0] mem_adrb;
  logic [15:0] mem_din, mem_dout;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
    logic        err;
  } resp_t;

  resp_t       sb[$];
  logic [7:0]  mem     [0:16383];
  logic [7:0]  ref_mem [0:16383];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_addr(p1_addr),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_rb(mem_rb), .mem_wb(mem_wb), .mem_adrb(mem_adrb), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Single-port memory, little-endian, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wb) begin
      mem[mem_adrb]         <= mem_din[7:0];
      mem[mem_adrb + 15'd1] <= mem_din[15:8];
    end
    if (mem_rb) mem_dout <= {mem[mem_adrb + 15'd1], mem[mem_adrb]};
  end

  function automatic logic [15:0] ref_word(input logic [14:0] a);
    return {ref_mem[a + 15'd1], ref_mem[a]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; p0_req = 1'b1; p0_we = 1'b1; p0_addr = 15'h0040; p0_wdata = 16'hA5A5;
    p1_req = 1'b1; p1_addr = 15'h0050;
    tick(); tick();
    @(negedge clk);
    checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", {p0_gnt, p1_gnt}); end
    checks++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0) begin errors++; $display("FAIL reset_rsp: got %b want 0000", {p0_rvalid, p1_rvalid, p0_err, p1_err}); end
    checks++; if ({mem_rb, mem_wb} !== 2'b00) begin errors++; $display("FAIL reset_strobe: got %b want 00", {mem_rb, mem_wb}); end
    checks++; if ({mem_adrb, mem_din, p0_rdata, p1_rdata} !== 63'd0) begin errors++; $display("FAIL reset_data: adrb %h din %h rd0 %h rd1 %h want 0", mem_adrb, mem_din, p0_rdata, p1_rdata); end
    tick();
    rst = 1'b0; p0_req = 1'b0; p0_we = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_release_rvalid: got %b want 00", {p0_rvalid, p1_rvalid}); end
  endtask

  task automatic test_fetch();
    resp_t r;
    tick();
    p1_req = 1'b1; p1_addr = 15'h0010;
    @(negedge clk);
    checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL fetch_gnt: got %b want 01", {p0_gnt, p1_gnt}); end
    checks++; if ({mem_rb, mem_wb} !== 2'b10) begin errors++; $display("FAIL fetch_strobe: got %b want 10", {mem_rb, mem_wb}); end
    checks++; if (mem_adrb !== 15'h0010) begin errors++; $display("FAIL fetch_adrb: got %h want 0010", mem_adrb); end
    sb.push_back('{port: 1'b1, data: ref_word(15'h0010), err: 1'b0});
    tick();
    p1_req = 1'b0;
    @(negedge clk);
    r = sb.pop_front();
    checks++; if (r.data !== 16'h1234) begin errors++; $display("FAIL fetch_ref: got %h want 1234", r.data); end
    checks++; if ({p1_rvalid, p1_err, p0_rvalid} !== 3'b100) begin errors++; $display("FAIL fetch_rsp: got %b want 100", {p1_rvalid, p1_err, p0_rvalid}); end
    checks++; if (p1_rdata !== r.data) begin errors++; $display("FAIL fetch_rdata: got %h want %h", p1_rdata, r.data); end
  endtask

  task automatic test_alternate();
    resp_t r;
    logic  exp_port;
    for (int i = 0; i < 7; i++) begin
      tick();
      p0_req = (i < 6); p0_we = 1'b0; p0_addr = 15'h0100;
      p1_req = (i < 6); p1_addr = 15'h0200;
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        checks++; if ((r.port ? p1_rvalid : p0_rvalid) !== 1'b1) begin errors++; $display("FAIL alt_rvalid[%0d]: port %0d got 0 want 1", i, r.port); end
        checks++; if ((r.port ? p0_rvalid : p1_rvalid) !== 1'b0) begin errors++; $display("FAIL alt_other_rvalid[%0d]: got 1 want 0", i); end
        checks++; if ((r.port ? p1_rdata : p0_rdata) !== r.data) begin errors++; $display("FAIL alt_rdata[%0d]: got %h want %h", i, r.port ? p1_rdata : p0_rdata, r.data); end
        checks++; if ((r.port ? p1_err : p0_err) !== 1'b0) begin errors++; $display("FAIL alt_err[%0d]: got 1 want 0", i); end
      end
      if (i < 6) begin
        exp_port = i[0];
        checks++; if ({p0_gnt, p1_gnt} !== (exp_port ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, {p0_gnt, p1_gnt}, exp_port ? 2'b01 : 2'b10); end
        checks++; if (mem_adrb !== (exp_port ? 15'h0200 : 15'h0100)) begin errors++; $display("FAIL alt_adrb[%0d]: got %h", i, mem_adrb); end
        sb.push_back('{port: exp_port, data: ref_word(exp_port ? 15'h0200 : 15'h0100), err: 1'b0});
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic test_write_read();
    resp_t r;
    tick();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 15'h0020; p0_wdata = 16'hBEEF;
    @(negedge clk);
    checks++; if ({p0_gnt, mem_wb, mem_rb} !== 3'b110) begin errors++; $display("FAIL wr_strobe: got %b want 110", {p0_gnt, mem_wb, mem_rb}); end
    checks++; if ({mem_adrb, mem_din} !== {15'h0020, 16'hBEEF}) begin errors++; $display("FAIL wr_bus: adrb %h din %h want 0020 beef", mem_adrb, mem_din); end
    ref_mem[15'h0020] = 8'hEF; ref_mem[15'h0021] = 8'hBE;
    tick();
    p0_we = 1'b0;
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got 1 want 0"); end
    checks++; if ({p0_gnt, mem_rb, mem_wb} !== 3'b110) begin errors++; $display("FAIL rd_after_wr_strobe: got %b want 110", {p0_gnt, mem_rb, mem_wb}); end
    sb.push_back('{port: 1'b0, data: ref_word(15'h0020), err: 1'b0});
    tick();
    p0_req = 1'b0;
    @(negedge clk);
    r = sb.pop_front();
    checks++; if ({p0_rvalid, p0_err} !== 2'b10) begin errors++; $display("FAIL rd_after_wr_rsp: got %b want 10", {p0_rvalid, p0_err}); end
    checks++; if (p0_rdata !== r.data) begin errors++; $display("FAIL rd_after_wr_rdata: got %h want %h", p0_rdata, r.data); end
  endtask

  task automatic test_illegal();
    resp_t r;
    // port, we, addr, expected legal
    logic [17:0] vec [0:4];
    vec[0] = {1'b1, 1'b0, 15'h0011, 1'b0};
    vec[1] = {1'b0, 1'b0, 15'h3FFF, 1'b0};
    vec[2] = {1'b0, 1'b1, 15'h4000, 1'b0};
    vec[3] = {1'b0, 1'b0, 15'h3FFE, 1'b1};
    vec[4] = {1'b1, 1'b0, 15'h7FFE, 1'b0};
    for (int i = 0; i < 6; i++) begin
      tick();
      p0_req = 1'b0; p1_req = 1'b0;
      if (i < 5) begin
        if (vec[i][17]) begin p1_req = 1'b1; p1_addr = vec[i][15:1]; end
        else begin p0_req = 1'b1; p0_we = vec[i][16]; p0_addr = vec[i][15:1]; p0_wdata = 16'h5A5A; end
      end
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        checks++; if ((r.port ? p1_rvalid : p0_rvalid) !== 1'b1) begin errors++; $display("FAIL ill_rvalid[%0d]: got 0 want 1", i); end
        checks++; if ((r.port ? p1_err : p0_err) !== r.err) begin errors++; $display("FAIL ill_err[%0d]: got %b want %b", i, r.port ? p1_err : p0_err, r.err); end
        checks++; if ((r.port ? p1_rdata : p0_rdata) !== r.data) begin errors++; $display("FAIL ill_rdata[%0d]: got %h want %h", i, r.port ? p1_rdata : p0_rdata, r.data); end
      end
      if (i < 5) begin
        checks++; if ((vec[i][17] ? p1_gnt : p0_gnt) !== 1'b1) begin errors++; $display("FAIL ill_gnt[%0d]: got 0 want 1", i); end
        checks++; if ((mem_rb | mem_wb) !== vec[i][0]) begin errors++; $display("FAIL ill_strobe[%0d]: got rb %b wb %b want %b", i, mem_rb, mem_wb, vec[i][0]); end
        sb.push_back('{port: vec[i][17], data: vec[i][0] ? ref_word(vec[i][15:1]) : 16'h0000, err: !vec[i][0]});
      end
    end
    p0_we = 1'b0;
  endtask

  task automatic test_reset_midflight();
    tick();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 15'h0100;
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt: got 0 want 1"); end
    for (int i = 0; i < 2; i++) begin
      tick();
      rst = 1'b1; p0_req = 1'b0; p1_req = 1'b1; p1_addr = 15'h0200;
      @(negedge clk);
      checks++; if ({p0_rvalid, p1_rvalid, p1_gnt, mem_rb} !== 4'b0) begin errors++; $display("FAIL mid_reset[%0d]: got %b want 0000", i, {p0_rvalid, p1_rvalid, p1_gnt, mem_rb}); end
    end
    tick();
    rst = 1'b0; p0_req = 1'b1;
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL mid_release_rvalid: got 1 want 0"); end
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin errors++; $display("FAIL mid_first_conflict: got %b want 10", {p0_gnt, p1_gnt}); end
    sb.push_back('{port: 1'b0, data: ref_word(15'h0100), err: 1'b0});
    tick();
    p0_req = 1'b0;
    @(negedge clk);
    checks++; if ({p0_rvalid, p0_rdata} !== {1'b1, sb[0].data}) begin errors++; $display("FAIL mid_rsp: got %b %h want 1 %h", p0_rvalid, p0_rdata, sb[0].data); end
    checks++; if (p1_gnt !== 1'b1) begin errors++; $display("FAIL mid_second_gnt: got 0 want 1"); end
    void'(sb.pop_front());
    tick();
    p1_req = 1'b0;
    @(negedge clk);
    checks++; if ({p1_rvalid, p1_rdata} !== {1'b1, ref_word(15'h0200)}) begin errors++; $display("FAIL mid_p1_rsp: got %b %h want 1 %h", p1_rvalid, p1_rdata, ref_word(15'h0200)); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
    ref_mem[16'h0010] = 8'h34; ref_mem[16'h0011] = 8'h12;
    test_reset();
    test_fetch();
    test_alternate();
    test_write_read();
    test_illegal();
    test_reset_midflight();
    tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d entries left want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
